// File: rtl/imem_pkg.sv
// Shared constants for the loadable instruction memory: state encoding,
// RV32I opcode fields used to build the NOP word, and the word-address check.
package imem_pkg;

   typedef enum logic [1:0] {
      ST_CLEAR = 2'd0,
      ST_LOAD  = 2'd1,
      ST_RUN   = 2'd2
   } imem_state_t;

   localparam logic [6:0]  OPC_OP_IMM   = 7'b0010011;
   localparam logic [2:0]  F3_ADDI      = 3'b000;
   // addi x0,x0,0
   localparam logic [31:0] NOP_WORD_DEF = {12'h000, 5'd0, F3_ADDI, 5'd0, OPC_OP_IMM};

   // A byte address names a stored word when it is word-aligned and below depth words.
   function automatic logic word_addr_ok(input logic [31:0] addr, input logic [31:0] depth);
      return (addr[1:0] == 2'b00) && ((addr >> 2) < depth);
   endfunction

endpackage

// File: rtl/imem_ram.sv
// Instruction storage: one write port and one registered, enable-gated read port.
module imem_ram #(
   parameter int DEPTH = 64,
   parameter int XLEN  = 32,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic            i_clk,
   input  logic            i_we,
   input  logic [AW-1:0]   i_waddr,
   input  logic [XLEN-1:0] i_wdata,
   input  logic            i_re,
   input  logic [AW-1:0]   i_raddr,
   output logic [XLEN-1:0] o_rdata
);

   logic [XLEN-1:0] r_mem [DEPTH];
   logic [XLEN-1:0] r_rdata;

   // Read data is not reset; the fetch logic masks it until a real fetch completes.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
      if (i_re) begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/imem_loadable.sv
// Loadable instruction memory: CLEAR fills with NOPs, LOAD accepts program words,
// RUN serves one-cycle registered fetches with fault reporting and stall hold.
module imem_loadable
   import imem_pkg::*;
#(
   parameter int              DEPTH    = 64,
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] NOP_WORD = XLEN'(NOP_WORD_DEF)
) (
   input  logic                   clk_50,
   input  logic                   rst,
   input  logic                   if_req,
   input  logic [31:0]            if_addr,
   input  logic                   if_stall,
   output logic [XLEN-1:0]        if_inst,
   output logic                   if_valid,
   output logic                   if_fault,
   input  logic                   ld_start,
   input  logic                   ld_we,
   input  logic [31:0]            ld_addr,
   input  logic [XLEN-1:0]        ld_data,
   input  logic                   ld_done,
   output logic [$clog2(DEPTH):0] ld_count,
   output logic [1:0]             mode
);

   localparam int AW = $clog2(DEPTH);

   imem_state_t     r_state;
   imem_state_t     w_state_nxt;
   logic [AW-1:0]   r_clr_cnt;
   logic [AW:0]     r_ld_count;
   logic            r_valid;
   logic            r_fault;
   logic            r_sel_mem;
   logic            w_ld_ok;
   logic            w_if_ok;
   logic            w_ld_acc;
   logic            w_run;
   logic            w_we;
   logic [AW-1:0]   w_waddr;
   logic [XLEN-1:0] w_wdata;
   logic [XLEN-1:0] w_rdata;

   assign w_run    = (r_state == ST_RUN);
   assign w_ld_ok  = word_addr_ok(ld_addr, 32'(DEPTH));
   assign w_if_ok  = word_addr_ok(if_addr, 32'(DEPTH));
   assign w_ld_acc = (r_state == ST_LOAD) && ld_we && w_ld_ok;

   // Single write port: the state alone selects between clear fill and load data.
   always_comb begin
      w_we    = 1'b0;
      w_waddr = r_clr_cnt;
      w_wdata = NOP_WORD;
      case (r_state)
         ST_CLEAR: w_we = ~rst;
         ST_LOAD: begin
            w_we    = w_ld_acc & ~rst;
            w_waddr = ld_addr[AW+1:2];
            w_wdata = ld_data;
         end
         default: w_we = 1'b0;
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_CLEAR: begin
            if (r_clr_cnt == AW'(DEPTH - 1)) w_state_nxt = ST_LOAD;
            else                             w_state_nxt = ST_CLEAR;
         end
         ST_LOAD: begin
            if (ld_done) w_state_nxt = ST_RUN;
            else         w_state_nxt = ST_LOAD;
         end
         ST_RUN: begin
            if (ld_start) w_state_nxt = ST_LOAD;
            else          w_state_nxt = ST_RUN;
         end
         default: w_state_nxt = ST_CLEAR;
      endcase
   end

   always_ff @(posedge clk_50) begin
      if (rst) begin
         r_state    <= ST_CLEAR;
         r_clr_cnt  <= '0;
         r_ld_count <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_clr_cnt <= (r_state == ST_CLEAR) ? r_clr_cnt + 1'b1 : '0;
         if ((r_state == ST_CLEAR) || (w_run && ld_start)) begin
            r_ld_count <= '0;
         end else if (w_ld_acc) begin
            r_ld_count <= r_ld_count + 1'b1;
         end else begin
            r_ld_count <= r_ld_count;
         end
      end
   end

   // Stall freezes both the flags and the RAM read register, so if_inst holds too.
   always_ff @(posedge clk_50) begin
      if (rst) begin
         r_valid   <= 1'b0;
         r_fault   <= 1'b0;
         r_sel_mem <= 1'b0;
      end else if (if_stall) begin
         r_valid   <= r_valid;
         r_fault   <= r_fault;
         r_sel_mem <= r_sel_mem;
      end else if (w_run && if_req) begin
         r_valid   <= 1'b1;
         r_fault   <= ~w_if_ok;
         r_sel_mem <= w_if_ok;
      end else begin
         r_valid   <= 1'b0;
         r_fault   <= 1'b0;
         r_sel_mem <= 1'b0;
      end
   end

   imem_ram #(
      .DEPTH (DEPTH),
      .XLEN  (XLEN),
      .AW    (AW)
   ) u_ram (
      .i_clk   (clk_50),
      .i_we    (w_we),
      .i_waddr (w_waddr),
      .i_wdata (w_wdata),
      .i_re    (~if_stall),
      .i_raddr (if_addr[AW+1:2]),
      .o_rdata (w_rdata)
   );

   assign if_inst  = r_sel_mem ? w_rdata : NOP_WORD;
   assign if_valid = r_valid;
   assign if_fault = r_fault;
   assign ld_count = r_ld_count;
   assign mode     = r_state;

endmodule

// File: tb/tb_imem_loadable.sv
// Scoreboard bench for imem_loadable: a behavioural memory/mode model predicts
// each fetch result when it is driven; results are popped and compared a cycle later.
module tb_imem_loadable;

   localparam int          DEPTH = 64;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic        clk_50 = 1'b0;
   logic        rst, if_req, if_stall, ld_start, ld_we, ld_done;
   logic [31:0] if_addr, ld_addr, ld_data, if_inst;
   logic        if_valid, if_fault;
   logic [6:0]  ld_count;
   logic [1:0]  mode;

   typedef struct packed {
      logic [31:0] inst;
      logic        valid;
      logic        fault;
   } exp_t;

   exp_t        sb_q[$];
   exp_t        last_exp;
   logic [31:0] model_mem [DEPTH];
   int          model_mode;
   int          model_cnt;
   int          tests_run = 0;
   int          fails     = 0;

   imem_loadable #(.DEPTH(DEPTH), .XLEN(32), .NOP_WORD(NOP)) dut (
      .clk_50   (clk_50),
      .rst      (rst),
      .if_req   (if_req),
      .if_addr  (if_addr),
      .if_stall (if_stall),
      .if_inst  (if_inst),
      .if_valid (if_valid),
      .if_fault (if_fault),
      .ld_start (ld_start),
      .ld_we    (ld_we),
      .ld_addr  (ld_addr),
      .ld_data  (ld_data),
      .ld_done  (ld_done),
      .ld_count (ld_count),
      .mode     (mode)
   );

   always #10 clk_50 = ~clk_50;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk_50);
      #1;
   endtask

   task automatic clear_inputs();
      rst = 1'b0; if_req = 1'b0; if_stall = 1'b0; if_addr = 32'h0;
      ld_start = 1'b0; ld_we = 1'b0; ld_done = 1'b0; ld_addr = 32'h0; ld_data = 32'h0;
   endtask

   // Reset with every other control input asserted; reset must win.
   task automatic do_reset();
      rst = 1'b1; if_req = 1'b1; if_stall = 1'b1; if_addr = 32'h50;
      ld_start = 1'b1; ld_we = 1'b1; ld_done = 1'b1; ld_addr = 32'h50; ld_data = 32'hffff_ffff;
      tick();
      clear_inputs();
      model_mode = 0;
      model_cnt  = 0;
      for (int i = 0; i < DEPTH; i++) model_mem[i] = NOP;
      last_exp = '{inst: NOP, valid: 1'b0, fault: 1'b0};
      sb_q.delete();
   endtask

   task automatic drive_fetch(input logic req, input logic [31:0] addr, input logic stall);
      exp_t e;
      if_req = req; if_addr = addr; if_stall = stall;
      if (stall) begin
         e = last_exp;
      end else if (req && model_mode == 2) begin
         if (addr[1:0] == 2'b00 && addr < 32'(DEPTH * 4))
            e = '{inst: model_mem[addr[7:2]], valid: 1'b1, fault: 1'b0};
         else
            e = '{inst: NOP, valid: 1'b1, fault: 1'b1};
      end else begin
         e = '{inst: NOP, valid: 1'b0, fault: 1'b0};
      end
      sb_q.push_back(e);
      last_exp = e;
      tick();
      if_req = 1'b0; if_stall = 1'b0;
   endtask

   task automatic load(input logic we, input logic [31:0] addr, input logic [31:0] data,
                       input logic start, input logic done);
      ld_we = we; ld_addr = addr; ld_data = data; ld_start = start; ld_done = done;
      if (model_mode == 1 && we && addr[1:0] == 2'b00 && addr < 32'(DEPTH * 4)) begin
         model_mem[addr[7:2]] = data;
         model_cnt++;
      end
      if (model_mode == 1 && done) begin
         model_mode = 2;
      end else if (model_mode == 2 && start) begin
         model_mode = 1;
         model_cnt  = 0;
      end
      tick();
      ld_we = 1'b0; ld_start = 1'b0; ld_done = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      tests_run++;
      if (mode !== 2'd0) begin fails++; $display("FAIL reset_mode: got %0d want 0", mode); end
      tests_run++;
      if (if_inst !== NOP) begin fails++; $display("FAIL reset_inst: got %h want %h", if_inst, NOP); end
      tests_run++;
      if (if_valid !== 1'b0 || if_fault !== 1'b0) begin
         fails++; $display("FAIL reset_flags: got v=%b f=%b want 0 0", if_valid, if_fault);
      end
      tests_run++;
      if (ld_count !== 7'd0) begin fails++; $display("FAIL reset_ldcount: got %0d want 0", ld_count); end
   endtask

   task automatic test_clear();
      exp_t e, got;
      repeat (62) tick();
      drive_fetch(1'b1, 32'h0, 1'b0);
      e = sb_q.pop_front(); got = {if_inst, if_valid, if_fault};
      tests_run++;
      if (got !== e) begin fails++; $display("FAIL clear_fetch: got %h want %h", got, e); end
      tests_run++;
      if (mode !== 2'd0) begin fails++; $display("FAIL clear_mode63: got %0d want 0", mode); end
      tick();
      model_mode = 1;
      tests_run++;
      if (mode !== 2'd1) begin fails++; $display("FAIL clear_mode64: got %0d want 1", mode); end
   endtask

   task automatic test_load_fetch();
      exp_t e, got;
      logic [31:0] addrs [3] = '{32'h0, 32'h50, 32'h54};
      drive_fetch(1'b1, 32'h50, 1'b0);
      e = sb_q.pop_front(); got = {if_inst, if_valid, if_fault};
      tests_run++;
      if (got !== e) begin fails++; $display("FAIL load_mode_fetch: got %h want %h", got, e); end
      load(1'b1, 32'h50, 32'h02d2_82b3, 1'b0, 1'b0);
      load(1'b1, 32'h54, 32'h00e2_8333, 1'b0, 1'b0);
      tests_run++;
      if (ld_count !== 7'(model_cnt)) begin fails++; $display("FAIL ld_count2: got %0d want %0d", ld_count, model_cnt); end
      load(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
      tests_run++;
      if (mode !== 2'(model_mode)) begin fails++; $display("FAIL run_mode: got %0d want %0d", mode, model_mode); end
      for (int i = 0; i < 3; i++) begin
         drive_fetch(1'b1, addrs[i], 1'b0);
         e = sb_q.pop_front(); got = {if_inst, if_valid, if_fault};
         tests_run++;
         if (got !== e) begin fails++; $display("FAIL run_fetch[%h]: got %h want %h", addrs[i], got, e); end
      end
   endtask

   task automatic test_fault();
      exp_t e, got;
      logic [31:0] addrs [4] = '{32'h52, 32'h100, 32'hfc, 32'h50};
      logic        reqs  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 4; i++) begin
         drive_fetch(reqs[i], addrs[i], 1'b0);
         e = sb_q.pop_front(); got = {if_inst, if_valid, if_fault};
         tests_run++;
         if (got !== e) begin fails++; $display("FAIL fault_fetch[%h]: got %h want %h", addrs[i], got, e); end
      end
   endtask

   task automatic test_stall();
      exp_t e, got;
      for (int i = 0; i < 5; i++) begin
         drive_fetch(1'b1, (i == 0) ? 32'h50 : 32'h54, (i >= 1 && i <= 3));
         e = sb_q.pop_front(); got = {if_inst, if_valid, if_fault};
         tests_run++;
         if (got !== e) begin fails++; $display("FAIL stall_step%0d: got %h want %h", i, got, e); end
      end
   endtask

   task automatic test_reload();
      exp_t e, got;
      logic [31:0] addrs [6] = '{32'h4, 32'h58, 32'h5c, 32'h60, 32'h50, 32'h54};
      load(1'b1, 32'h60, 32'hdead_beef, 1'b0, 1'b0);
      load(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
      tests_run++;
      if (mode !== 2'(model_mode)) begin fails++; $display("FAIL run_ignores_done: got %0d want %0d", mode, model_mode); end
      load(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      tests_run++;
      if (mode !== 2'(model_mode) || ld_count !== 7'(model_cnt)) begin
         fails++; $display("FAIL reload_enter: got mode=%0d cnt=%0d want %0d %0d", mode, ld_count, model_mode, model_cnt);
      end
      load(1'b1, 32'h200, 32'h1111_1111, 1'b0, 1'b0);
      load(1'b1, 32'h6, 32'h2222_2222, 1'b0, 1'b0);
      tests_run++;
      if (ld_count !== 7'(model_cnt)) begin fails++; $display("FAIL bad_writes_cnt: got %0d want %0d", ld_count, model_cnt); end
      load(1'b1, 32'h58, 32'h0040_0093, 1'b1, 1'b0);
      tests_run++;
      if (mode !== 2'(model_mode) || ld_count !== 7'(model_cnt)) begin
         fails++; $display("FAIL start_in_load: got mode=%0d cnt=%0d want %0d %0d", mode, ld_count, model_mode, model_cnt);
      end
      load(1'b1, 32'h5c, 32'h0010_8113, 1'b0, 1'b1);
      tests_run++;
      if (mode !== 2'(model_mode) || ld_count !== 7'(model_cnt)) begin
         fails++; $display("FAIL write_with_done: got mode=%0d cnt=%0d want %0d %0d", mode, ld_count, model_mode, model_cnt);
      end
      for (int i = 0; i < 6; i++) begin
         drive_fetch(1'b1, addrs[i], 1'b0);
         e = sb_q.pop_front(); got = {if_inst, if_valid, if_fault};
         tests_run++;
         if (got !== e) begin fails++; $display("FAIL reload_fetch[%h]: got %h want %h", addrs[i], got, e); end
      end
   endtask

   task automatic test_reset_mid_run();
      exp_t e, got;
      do_reset();
      tests_run++;
      if (mode !== 2'd0 || if_valid !== 1'b0) begin
         fails++; $display("FAIL midrun_reset: got mode=%0d v=%b want 0 0", mode, if_valid);
      end
      repeat (DEPTH) tick();
      model_mode = 1;
      load(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
      tests_run++;
      if (mode !== 2'd2 || ld_count !== 7'd0) begin
         fails++; $display("FAIL midrun_run: got mode=%0d cnt=%0d want 2 0", mode, ld_count);
      end
      drive_fetch(1'b1, 32'h50, 1'b0);
      e = sb_q.pop_front(); got = {if_inst, if_valid, if_fault};
      tests_run++;
      if (got !== e) begin fails++; $display("FAIL midrun_fetch: got %h want %h", got, e); end
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_clear();
      test_load_fetch();
      test_fault();
      test_stall();
      test_reload();
      test_reset_mid_run();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule

// File: doc/imem_loadable.md
IMEM_LOADABLE -- requirements
Module: imem_loadable

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning instruction words stored (power of two, 16..1024).
REQ-002 SHALL have parameter XLEN, default 32, meaning instruction and data width in bits.
REQ-003 SHALL have parameter NOP_WORD, default 32'h00000013, meaning the fill and bubble instruction (addi x0,x0,0).
REQ-004 clk_50  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 if_req  input  1  fetch request from the pipeline IF stage.
REQ-007 if_addr  input  32  fetch byte address.
REQ-008 if_stall  input  1  hold the current fetch output.
REQ-009 if_inst  output  XLEN  fetched instruction (registered).
REQ-010 if_valid  output  1  if_inst carries a real fetch result.
REQ-011 if_fault  output  1  last fetch was misaligned or out of range.
REQ-012 ld_start  input  1  pulse: enter program-load mode.
REQ-013 ld_we  input  1  load-port write strobe.
REQ-014 ld_addr  input  32  load-port byte address.
REQ-015 ld_data  input  XLEN  load-port write data.
REQ-016 ld_done  input  1  pulse: leave load mode and start running.
REQ-017 ld_count  output  $clog2(DEPTH)+1  number of accepted load writes since entering LOAD.
REQ-018 mode  output  2  current state encoding (CLEAR=0, LOAD=1, RUN=2).

Function
REQ-019 SHALL implement states CLEAR, LOAD and RUN.
REQ-020 CLEAR: the block SHALL write NOP_WORD to word index clr_cnt each cycle, clr_cnt running 0..DEPTH-1, and SHALL enter LOAD after writing index DEPTH-1, so CLEAR lasts exactly DEPTH cycles.
REQ-021 LOAD: a cycle with ld_we=1 and ld_addr aligned (ld_addr[1:0]=0) and in range (ld_addr>>2 < DEPTH) SHALL write ld_data to word ld_addr>>2 and increment ld_count; any other write SHALL be dropped and SHALL leave ld_count unchanged.
REQ-022 LOAD: ld_done SHALL move the state to RUN on the next edge; a write in the same cycle as ld_done SHALL still be performed.
REQ-023 RUN: ld_start SHALL move the state to LOAD and SHALL clear ld_count to 0; ld_we outside LOAD SHALL be ignored.
REQ-024 ld_start in CLEAR or LOAD, and ld_done in CLEAR or RUN, SHALL be ignored.
REQ-025 Fetch latency SHALL be one cycle: the result for if_req/if_addr sampled at edge N SHALL appear on if_inst/if_valid/if_fault after edge N.
REQ-026 RUN with if_req=1 and if_stall=0: an aligned, in-range address SHALL give if_inst=mem[if_addr>>2], if_valid=1 and if_fault=0.
REQ-027 RUN with if_req=1 and if_stall=0: a misaligned or out-of-range address SHALL give if_inst=NOP_WORD, if_valid=1 and if_fault=1.
REQ-028 if_stall=1 SHALL hold if_inst, if_valid and if_fault unchanged, with no exception (stall has priority over every other fetch condition).
REQ-029 if_req=0 without stall, or any fetch outside RUN without stall, SHALL give if_inst=NOP_WORD, if_valid=0 and if_fault=0.
REQ-030 Memory writes SHALL use a single write port, with CLEAR and LOAD mutually exclusive by state.
REQ-031 A fetch to the same word as a LOAD write in the same cycle is impossible, because fetches return data only in RUN.

Reset
REQ-032 rst SHALL force state CLEAR, clr_cnt=0, ld_count=0, if_inst=NOP_WORD, if_valid=0 and if_fault=0 on the next edge.
REQ-033 rst asserted mid-LOAD or mid-RUN SHALL abort the operation and restart CLEAR, so all memory contents return to NOP_WORD.
REQ-034 rst SHALL override ld_start, ld_done, ld_we, if_req and if_stall in the same cycle.

Structure
REQ-035 The state encoding, NOP_WORD default and opcode constants SHALL live in a shared package, imem_pkg.
REQ-036 The storage SHALL be one sub-module, imem_ram: a single write port and one registered read port, synthesisable to block RAM.
REQ-037 The FSM, clear counter, address checks and output registers SHALL reside in imem_loadable.

Verification
REQ-038 Reset, then 64 cycles idle -> mode=1 at cycle 64; a RUN fetch of addr 0x0 afterwards returns 0x00000013.
REQ-039 LOAD writes 0x02d282b3 to 0x50 and 0x00e28333 to 0x54, then ld_done; fetch 0x50 then 0x54 -> if_inst=0x02d282b3 then 0x00e28333 one cycle later, if_valid=1, ld_count=2.
REQ-040 Fetch 0x52 and 0x100 (DEPTH=64) -> if_fault=1, if_inst=0x00000013, if_valid=1.
REQ-041 Fetch 0x50 and then assert if_stall for 3 cycles with if_addr=0x54 -> if_inst stays 0x02d282b3 for 3 cycles, then shows 0x00e28333.
REQ-042 Load ld_we to 0x200 or 0x6 -> ld_count unchanged and memory unchanged.
REQ-043 rst mid-RUN after a load -> after DEPTH cycles, fetch of 0x50 returns 0x00000013.
